ram_clear_sched: RTL and testbench
==================================

RAM_CLEAR_SCHED -- requirements
Module: ram_clear_sched

Interface
- REQ-001: Parameter SDR_AW, default 25, SDRAM word-address width.
- REQ-002: Parameter DDR_AW, default 29, DDR3 64-bit-word address width.
- REQ-003: Parameter SDR_GAP, default 31, idle cycles after each SDRAM write pulse; range 1..255.
- REQ-004: clk_sys  in  1  sole clock; all logic on its rising edge.
- REQ-005: reset_n  in  1  asynchronous, active-low reset.
- REQ-006: start  in  1  clear request; sampled every cycle, level or pulse.
- REQ-007: pause  in  1  when 1, no new write is scheduled.
- REQ-008: sdr_busy  in  1  SDRAM port not ready.
- REQ-009: sdr_we  out  1  one-cycle SDRAM write strobe; data is implicitly zero.
- REQ-010: sdr_addr  out  SDR_AW  SDRAM write address.
- REQ-011: ddr_busy  in  1  DDR3 Avalon waitrequest.
- REQ-012: ddr_we  out  1  DDR3 write request, Avalon hold semantics.
- REQ-013: ddr_addr  out  DDR_AW  DDR3 write address.
- REQ-014: busy  out  1  clear in progress.
- REQ-015: done  out  1  both memories fully cleared since last start.

Function
- REQ-016: States: IDLE, SCHED, SDR_ISSUE, SDR_GAP, DDR_ISSUE, FIN.
- REQ-017: IDLE or FIN with start=1 -> SCHED next cycle, with these actions:
  - sdr_addr and ddr_addr set to 0
  - sdr_fin and ddr_fin (internal) set to 0
  - done set to 0, busy set to 1
- REQ-018: start in any other state is ignored; an in-progress clear is never restarted.
- REQ-019: SCHED with pause=1 holds SCHED.
- REQ-020: SCHED with pause=0 selects the next channel as follows:
  - both channels unfinished: serve the channel not served last (round-robin); the first pick after start is SDRAM
  - one channel finished: serve the other
  - both finished: go to FIN
- REQ-021: SDR_ISSUE with sdr_busy=1 holds and sdr_we stays 0.
- REQ-022: SDR_ISSUE with sdr_busy=0 drives sdr_we=1 for exactly one cycle, then enters SDR_GAP with the gap counter loaded to SDR_GAP.
- REQ-023: SDR_GAP decrements the counter each cycle and leaves when it reaches 0.
  - On exit with sdr_addr all-ones: sdr_fin=1 and sdr_addr holds.
  - Otherwise: sdr_addr increments by 1.
  - Next state is SCHED in both cases.
- REQ-024: DDR_ISSUE drives ddr_we=1 continuously; ddr_addr is stable while ddr_we=1.
- REQ-025: A DDR write is accepted on the cycle where ddr_we=1 and ddr_busy=0.
  - ddr_we drops on the following cycle; next state is SCHED.
  - Accepted at address all-ones: ddr_fin=1 and ddr_addr holds.
  - Otherwise: ddr_addr increments by 1.
- REQ-026: pause only stops scheduling from SCHED; a write already in ISSUE or GAP completes.
- REQ-027: FIN: done=1, busy=0; holds until start.
- REQ-028: At most one of sdr_we and ddr_we is 1 in any cycle.
- REQ-029: Address increments are modulo 2^width, but never wrap past all-ones (see REQ-023, REQ-025).

Reset
- REQ-030: reset_n=0 immediately, without waiting for a clock edge:
  - forces IDLE
  - clears both addresses, the gap counter, sdr_fin, ddr_fin and the round-robin pointer
  - drives sdr_we=0, ddr_we=0, busy=0, done=0
- REQ-031: Reset asserted mid-write abandons the write; ddr_we drops asynchronously regardless of ddr_busy.
- REQ-032: The first cycle after reset_n deasserts is IDLE; start is honoured from that edge onward.

Verification
Scenarios use SDR_AW=2, DDR_AW=2, SDR_GAP=2.
- REQ-033: Basic clear. Busy inputs 0, one-cycle start.
  - Writes alternate S0,D0,S1,D1,S2,D2,S3,D3.
  - Each sdr_we is followed by exactly 2 gap cycles.
  - Then done=1, busy=0; exactly 4 pulses on each channel.
- REQ-034: DDR backpressure. ddr_busy=1 for 5 cycles during D1.
  - ddr_we held 6 cycles with ddr_addr=1.
  - Exactly one D1 accepted.
  - Sequence otherwise as in REQ-033.
- REQ-035: Pause. pause=1 asserted while SDR_GAP follows S1.
  - S1 gap completes.
  - No write issued while pause=1.
  - After release, resumes with D1.
- REQ-036: Reset mid-write. reset_n=0 during DDR_ISSUE with ddr_busy=1.
  - All outputs 0 in the same cycle.
  - After release plus start, sequence restarts at S0.
- REQ-037: Start handling.
  - start held high during the clear: no restart, and done rises once at the end.
  - start asserted in FIN: done drops the next cycle and S0 is reissued.

Source files
------------

// File: rtl/ram_clear_sched.sv
// Zero-fill scheduler for an SDRAM and a DDR3 port: walks both address spaces,
// alternating writes round-robin, and reports done once both are cleared.
module ram_clear_sched #(
    parameter int SDR_AW  = 25,
    parameter int DDR_AW  = 29,
    parameter int SDR_GAP = 31
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic              pause,
    input  logic              sdr_busy,
    output logic              sdr_we,
    output logic [SDR_AW-1:0] sdr_addr,
    input  logic              ddr_busy,
    output logic              ddr_we,
    output logic [DDR_AW-1:0] ddr_addr,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0] GAP_LOAD = 8'(SDR_GAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCHED,
        S_SDR_ISSUE,
        S_SDR_GAP,
        S_DDR_ISSUE,
        S_FIN
    } state_t;

    state_t            r_state,    w_state_nxt;
    logic [SDR_AW-1:0] r_sdr_addr, w_sdr_addr_nxt;
    logic [DDR_AW-1:0] r_ddr_addr, w_ddr_addr_nxt;
    logic [7:0]        r_gap,      w_gap_nxt;
    logic              r_sdr_fin,  w_sdr_fin_nxt;
    logic              r_ddr_fin,  w_ddr_fin_nxt;
    logic              r_next_ddr, w_next_ddr_nxt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_sdr_addr <= '0;
            r_ddr_addr <= '0;
            r_gap      <= '0;
            r_sdr_fin  <= 1'b0;
            r_ddr_fin  <= 1'b0;
            r_next_ddr <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sdr_addr <= w_sdr_addr_nxt;
            r_ddr_addr <= w_ddr_addr_nxt;
            r_gap      <= w_gap_nxt;
            r_sdr_fin  <= w_sdr_fin_nxt;
            r_ddr_fin  <= w_ddr_fin_nxt;
            r_next_ddr <= w_next_ddr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sdr_addr_nxt = r_sdr_addr;
        w_ddr_addr_nxt = r_ddr_addr;
        w_gap_nxt      = r_gap;
        w_sdr_fin_nxt  = r_sdr_fin;
        w_ddr_fin_nxt  = r_ddr_fin;
        w_next_ddr_nxt = r_next_ddr;
        sdr_we         = 1'b0;
        ddr_we         = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;

        case (r_state)
            S_IDLE, S_FIN: begin
                busy = 1'b0;
                done = (r_state == S_FIN);
                if (start) begin
                    w_state_nxt    = S_SCHED;
                    w_sdr_addr_nxt = '0;
                    w_ddr_addr_nxt = '0;
                    w_sdr_fin_nxt  = 1'b0;
                    w_ddr_fin_nxt  = 1'b0;
                    w_next_ddr_nxt = 1'b0;
                end
            end
            S_SCHED: begin
                // Round-robin only matters while both channels still have work.
                if (!pause) begin
                    if (r_sdr_fin && r_ddr_fin) w_state_nxt = S_FIN;
                    else if (r_sdr_fin)         w_state_nxt = S_DDR_ISSUE;
                    else if (r_ddr_fin)         w_state_nxt = S_SDR_ISSUE;
                    else if (r_next_ddr)        w_state_nxt = S_DDR_ISSUE;
                    else                        w_state_nxt = S_SDR_ISSUE;
                end
            end
            S_SDR_ISSUE: begin
                if (!sdr_busy) begin
                    sdr_we         = 1'b1;
                    w_gap_nxt      = GAP_LOAD;
                    w_next_ddr_nxt = 1'b1;
                    w_state_nxt    = S_SDR_GAP;
                end
            end
            S_SDR_GAP: begin
                if (r_gap <= 8'd1) begin
                    w_gap_nxt   = '0;
                    w_state_nxt = S_SCHED;
                    if (&r_sdr_addr) w_sdr_fin_nxt  = 1'b1;
                    else             w_sdr_addr_nxt = r_sdr_addr + SDR_AW'(1);
                end else begin
                    w_gap_nxt = r_gap - 8'd1;
                end
            end
            S_DDR_ISSUE: begin
                ddr_we = 1'b1;
                if (!ddr_busy) begin
                    w_next_ddr_nxt = 1'b0;
                    w_state_nxt    = S_SCHED;
                    if (&r_ddr_addr) w_ddr_fin_nxt  = 1'b1;
                    else             w_ddr_addr_nxt = r_ddr_addr + DDR_AW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign sdr_addr = r_sdr_addr;
    assign ddr_addr = r_ddr_addr;

endmodule

// File: tb/tb_ram_clear_sched.sv
// Bench for ram_clear_sched: a procedural model walks the expected write order
// phase by phase while driving randomised busy/pause inputs and checking outputs.
module tb_ram_clear_sched;

    localparam int SAW = 2;
    localparam int DAW = 2;
    localparam int GAP = 2;

    logic           clk_sys = 1'b0;
    logic           reset_n = 1'b1;
    logic           start = 1'b0;
    logic           pause = 1'b0;
    logic           sdr_busy = 1'b0;
    logic           ddr_busy = 1'b0;
    logic           sdr_we;
    logic           ddr_we;
    logic [SAW-1:0] sdr_addr;
    logic [DAW-1:0] ddr_addr;
    logic           busy;
    logic           done;

    int n_tests = 0;
    int n_fail  = 0;
    int sdr_pulses;

    ram_clear_sched #(
        .SDR_AW (SAW),
        .DDR_AW (DAW),
        .SDR_GAP(GAP)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .start   (start),
        .pause   (pause),
        .sdr_busy(sdr_busy),
        .sdr_we  (sdr_we),
        .sdr_addr(sdr_addr),
        .ddr_busy(ddr_busy),
        .ddr_we  (ddr_we),
        .ddr_addr(ddr_addr),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic rnd_inputs();
        pause    = 1'($urandom_range(0, 1));
        sdr_busy = 1'($urandom_range(0, 1));
        ddr_busy = 1'($urandom_range(0, 1));
    endtask

    // Scheduling slot: no write, busy high; repeats while pause is held.
    task automatic sched_phase(input int npause);
        int n = 0;
        do begin
            rnd_inputs();
            if (npause >= 0) pause = 1'(n < npause);
            else             pause = 1'((n < 4) && ($urandom_range(0, 2) == 0));
            #1;
            chk("sched_sdr_we", 32'(sdr_we), 0);
            chk("sched_ddr_we", 32'(ddr_we), 0);
            chk("sched_busy",   32'(busy),   1);
            chk("sched_done",   32'(done),   0);
            n++;
            cyc();
        end while (pause);
    endtask

    task automatic sdr_phase(input int addr, input bit rnd, input bit pause_gap);
        int n = 0;
        do begin
            rnd_inputs();
            sdr_busy = rnd ? 1'((n < 5) && ($urandom_range(0, 1) == 1)) : 1'b0;
            #1;
            chk("sdr_we",       32'(sdr_we),   32'(!sdr_busy));
            chk("sdr_ddr_we",   32'(ddr_we),   0);
            chk("sdr_addr",     32'(sdr_addr), 32'(addr));
            chk("sdr_busy_out", 32'(busy),     1);
            if (sdr_we) sdr_pulses++;
            n++;
            cyc();
        end while (sdr_busy);
        for (int i = 0; i < GAP; i++) begin
            rnd_inputs();
            if (pause_gap) pause = 1'b1;
            #1;
            chk("gap_sdr_we", 32'(sdr_we), 0);
            chk("gap_ddr_we", 32'(ddr_we), 0);
            chk("gap_busy",   32'(busy),   1);
            cyc();
        end
    endtask

    task automatic ddr_phase(input int addr, input int nbusy);
        int n = 0;
        do begin
            rnd_inputs();
            if (nbusy >= 0) ddr_busy = 1'(n < nbusy);
            else            ddr_busy = 1'((n < 5) && ($urandom_range(0, 1) == 1));
            #1;
            chk("ddr_we",       32'(ddr_we),   1);
            chk("ddr_sdr_we",   32'(sdr_we),   0);
            chk("ddr_addr",     32'(ddr_addr), 32'(addr));
            chk("ddr_busy_out", 32'(busy),     1);
            n++;
            cyc();
        end while (ddr_busy);
    endtask

    // Full clear: S0,D0,S1,D1,S2,D2,S3,D3 then FIN with both addresses held at all-ones.
    task automatic run_clear(input bit from_fin, input int hold_txn, input int d1_busy,
                             input bit pause_s1, input bit rnd);
        int np;
        int nb;
        sdr_pulses = 0;
        rnd_inputs();
        start = 1'b1;
        #1;
        chk("start_busy", 32'(busy), 0);
        chk("start_done", 32'(done), 32'(from_fin));
        cyc();
        for (int k = 0; k < 8; k++) begin
            if (k >= hold_txn) start = 1'b0;
            np = (pause_s1 && k == 3) ? 3 : (rnd ? -1 : 0);
            sched_phase(np);
            if (k % 2 == 0) begin
                sdr_phase(k / 2, rnd, pause_s1 && k == 2);
            end else begin
                nb = (k == 3 && d1_busy > 0) ? d1_busy : (rnd ? -1 : 0);
                ddr_phase(k / 2, nb);
            end
        end
        start = 1'b0;
        sched_phase(rnd ? -1 : 0);
        for (int i = 0; i < 3; i++) begin
            rnd_inputs();
            #1;
            chk("fin_done",     32'(done),     1);
            chk("fin_busy",     32'(busy),     0);
            chk("fin_sdr_we",   32'(sdr_we),   0);
            chk("fin_ddr_we",   32'(ddr_we),   0);
            chk("fin_sdr_addr", 32'(sdr_addr), 32'((1 << SAW) - 1));
            chk("fin_ddr_addr", 32'(ddr_addr), 32'((1 << DAW) - 1));
            cyc();
        end
        chk("sdr_pulse_count", 32'(sdr_pulses), 4);
    endtask

    task automatic reset_mid_write();
        rnd_inputs();
        start = 1'b1;
        #1;
        chk("rst_pre_done", 32'(done), 1);
        cyc();
        start = 1'b0;
        sched_phase(0);
        sdr_phase(0, 1'b0, 1'b0);
        sched_phase(0);
        rnd_inputs();
        ddr_busy = 1'b1;
        #1;
        chk("rst_pre_ddr_we", 32'(ddr_we), 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_sdr_we",   32'(sdr_we),   0);
        chk("rst_ddr_we",   32'(ddr_we),   0);
        chk("rst_busy",     32'(busy),     0);
        chk("rst_done",     32'(done),     0);
        chk("rst_sdr_addr", 32'(sdr_addr), 0);
        chk("rst_ddr_addr", 32'(ddr_addr), 0);
        cyc();
        cyc();
        reset_n = 1'b1;
        rnd_inputs();
        #1;
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_done", 32'(done), 0);
        chk("post_rst_we",   32'({sdr_we, ddr_we}), 0);
        cyc();
    endtask

    initial begin
        #1;
        reset_n = 1'b0;
        #2;
        chk("reset_sdr_we",   32'(sdr_we),   0);
        chk("reset_ddr_we",   32'(ddr_we),   0);
        chk("reset_busy",     32'(busy),     0);
        chk("reset_done",     32'(done),     0);
        chk("reset_sdr_addr", 32'(sdr_addr), 0);
        chk("reset_ddr_addr", 32'(ddr_addr), 0);
        cyc();
        cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rnd_inputs();
            start = 1'b0;
            #1;
            chk("idle_busy", 32'(busy), 0);
            chk("idle_done", 32'(done), 0);
            chk("idle_we",   32'({sdr_we, ddr_we}), 0);
            cyc();
        end

        run_clear(1'b0, 0, 0, 1'b0, 1'b0);  // basic clear from IDLE
        run_clear(1'b1, 0, 5, 1'b0, 1'b0);  // D1 backpressure, started from FIN
        run_clear(1'b1, 0, 0, 1'b1, 1'b0);  // pause during S1 gap
        run_clear(1'b1, 5, 0, 1'b0, 1'b0);  // start held through most of the clear
        reset_mid_write();
        run_clear(1'b0, 0, 0, 1'b0, 1'b1);
        for (int r = 0; r < 4; r++)
            run_clear(1'b1, int'($urandom_range(0, 7)), 0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
